// File: rtl/cmt_rob_pkg.sv
// ============================================================================
//  Module  : cmt_rob_pkg
//  Brief   : Shared widths, entry layout and depth helpers for the cmt_rob ROB.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef NCPU_LRF_AW
`define NCPU_LRF_AW 5
`endif
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

package cmt_rob_pkg;
    localparam int LRF_AW = `NCPU_LRF_AW;
    localparam int PRF_AW = `NCPU_PRF_AW;

    localparam int CONFIG_P_ROB_DEPTH_DEF = 4;
    localparam int ROB_AW = CONFIG_P_ROB_DEPTH_DEF;
    localparam int DEPTH  = 1 << ROB_AW;

    // Packed entry layout, LSB first: pfree, prd_we, prd, lrd
    localparam int E_PFREE_LSB = 0;
    localparam int E_WE_BIT    = PRF_AW;
    localparam int E_PRD_LSB   = PRF_AW + 1;
    localparam int E_LRD_LSB   = 2 * PRF_AW + 1;
    localparam int ENTRY_W     = E_LRD_LSB + LRF_AW;

    function automatic int rob_aw(input int p_depth);
        return p_depth;
    endfunction
endpackage

`default_nettype wire

// File: rtl/cmt_rob_sel.sv
// ============================================================================
//  Module  : cmt_rob_sel
//  Brief   : Head-window read and in-order fire chain (exception cut when
//            CMT_ROB_EXC_EN is defined).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmt_rob_sel
    import cmt_rob_pkg::*;
#(
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_P_ROB_DEPTH    = 4,
    localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH,
    localparam int ID_W  = rob_aw(CONFIG_P_ROB_DEPTH),
    localparam int N_ENT = 1 << ID_W
) (
    input  logic [ID_W-1:0]          head,
    input  logic [N_ENT-1:0]         valid,
    input  logic [N_ENT-1:0]         done,
`ifdef CMT_ROB_EXC_EN
    input  logic [N_ENT-1:0]         exc,
    output logic                     cmt_exc,
`endif
    input  logic [N_ENT*ENTRY_W-1:0] entries,
    output logic [CW-1:0]            fire,
    output logic [ID_W:0]            fire_cnt,
    output logic [CW*LRF_AW-1:0]     lrd,
    output logic [CW*PRF_AW-1:0]     prd,
    output logic [CW-1:0]            prd_we,
    output logic [CW*PRF_AW-1:0]     pfree
);

    logic [ID_W-1:0]    w_idx;
    logic [ENTRY_W-1:0] w_ent;
    logic               w_ok;
    logic               w_chain;
    logic               w_exc_hit;

    always_comb begin
        fire      = '0;
        fire_cnt  = '0;
        lrd       = '0;
        prd       = '0;
        prd_we    = '0;
        pfree     = '0;
        w_idx     = '0;
        w_ent     = '0;
        w_ok      = 1'b0;
        w_chain   = 1'b1;
        w_exc_hit = 1'b0;
        for (int k = 0; k < CW; k++) begin
            w_idx = head + ID_W'(k);
            w_ent = entries[w_idx*ENTRY_W +: ENTRY_W];
            lrd[k*LRF_AW +: LRF_AW]   = w_ent[E_LRD_LSB +: LRF_AW];
            prd[k*PRF_AW +: PRF_AW]   = w_ent[E_PRD_LSB +: PRF_AW];
            prd_we[k]                 = w_ent[E_WE_BIT];
            pfree[k*PRF_AW +: PRF_AW] = w_ent[E_PFREE_LSB +: PRF_AW];
            w_ok = w_chain & valid[w_idx] & done[w_idx];
`ifdef CMT_ROB_EXC_EN
            // The faulting entry stays put; everything older still retires.
            if (w_ok && exc[w_idx]) begin
                w_exc_hit = 1'b1;
                w_ok      = 1'b0;
            end
`endif
            fire[k]  = w_ok;
            w_chain  = w_ok;
            fire_cnt = fire_cnt + {{ID_W{1'b0}}, w_ok};
        end
    end

`ifdef CMT_ROB_EXC_EN
    assign cmt_exc = w_exc_hit;
`endif

endmodule

`default_nettype wire

// File: rtl/cmt_rob.sv
// ============================================================================
//  Module  : cmt_rob
//  Brief   : In-order reorder buffer closing the rename/commit loop.
//            Optional exception cut enabled by macro CMT_ROB_EXC_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cmt_rob
    import cmt_rob_pkg::*;
#(
    parameter int CONFIG_P_ISSUE_WIDTH     = 1,
    parameter int CONFIG_P_COMMIT_WIDTH    = 1,
    parameter int CONFIG_P_WRITEBACK_WIDTH = 1,
    parameter int CONFIG_P_ROB_DEPTH       = 4,
    localparam int IW    = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH,
    localparam int WW    = 1 << CONFIG_P_WRITEBACK_WIDTH,
    localparam int ID_W  = rob_aw(CONFIG_P_ROB_DEPTH),
    localparam int N_ENT = 1 << ID_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [IW-1:0]                   rob_push,
    input  logic [CONFIG_P_ISSUE_WIDTH:0]   rob_push_size,
    input  logic [IW*LRF_AW-1:0]            rob_lrd,
    input  logic [IW*PRF_AW-1:0]            rob_prd,
    input  logic [IW-1:0]                   rob_prd_we,
    input  logic [IW*PRF_AW-1:0]            rob_pfree,
    output logic                            rob_ready,
    output logic [IW*ID_W-1:0]              rob_id,
    input  logic [WW-1:0]                   wb_valid,
    input  logic [WW*ID_W-1:0]              wb_rob_id,
`ifdef CMT_ROB_EXC_EN
    input  logic [WW-1:0]                   wb_exc,
    output logic                            cmt_exc,
`endif
    output logic [CW-1:0]                   cmt_fire,
    output logic [CW*LRF_AW-1:0]            cmt_lrd,
    output logic [CW*PRF_AW-1:0]            cmt_prd,
    output logic [CW-1:0]                   cmt_prd_we,
    output logic [CW*PRF_AW-1:0]            cmt_pfree,
    output logic [ID_W:0]                   rob_count
);

    logic [ID_W-1:0]          r_head;
    logic [ID_W-1:0]          r_tail;
    logic [ID_W:0]            r_count;
    logic [N_ENT-1:0]         r_valid;
    logic [N_ENT-1:0]         r_done;
    logic [ENTRY_W-1:0]       r_ent [N_ENT];
    logic [N_ENT*ENTRY_W-1:0] w_ent_flat;
    logic [ID_W:0]            w_free;
    logic [ID_W:0]            w_push_n;
    logic [ID_W:0]            w_fire_n;
    logic                     w_push_ok;
    logic                     w_clear;
    logic [ID_W-1:0]          w_push_idx [IW];
    logic [ID_W-1:0]          w_cmt_idx [CW];

`ifdef CMT_ROB_EXC_EN
    logic [N_ENT-1:0]         r_exc;
    logic                     w_exc;
    assign w_clear = flush | w_exc;
    assign cmt_exc = w_exc;
`else
    assign w_clear = flush;
`endif

    // Readiness looks only at registered occupancy; no same-cycle commit credit.
    assign w_free    = (ID_W+1)'(N_ENT) - r_count;
    assign rob_ready = (w_free >= (ID_W+1)'(IW));
    assign rob_count = r_count;
    assign w_push_ok = rob_ready & ~w_clear;
    assign w_push_n  = w_push_ok ? (ID_W+1)'(rob_push_size) : '0;

    for (genvar e = 0; e < N_ENT; e++) begin : g_flat
        assign w_ent_flat[e*ENTRY_W +: ENTRY_W] = r_ent[e];
    end

    for (genvar i = 0; i < IW; i++) begin : g_push_lane
        assign w_push_idx[i]             = r_tail + ID_W'(i);
        assign rob_id[i*ID_W +: ID_W]    = w_push_idx[i];
    end

    for (genvar k = 0; k < CW; k++) begin : g_cmt_lane
        assign w_cmt_idx[k] = r_head + ID_W'(k);
    end

    cmt_rob_sel #(
        .CONFIG_P_COMMIT_WIDTH (CONFIG_P_COMMIT_WIDTH),
        .CONFIG_P_ROB_DEPTH    (CONFIG_P_ROB_DEPTH)
    ) u_sel (
        .head     (r_head),
        .valid    (r_valid),
        .done     (r_done),
`ifdef CMT_ROB_EXC_EN
        .exc      (r_exc),
        .cmt_exc  (w_exc),
`endif
        .entries  (w_ent_flat),
        .fire     (cmt_fire),
        .fire_cnt (w_fire_n),
        .lrd      (cmt_lrd),
        .prd      (cmt_prd),
        .prd_we   (cmt_prd_we),
        .pfree    (cmt_pfree)
    );

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
`ifdef CMT_ROB_EXC_EN
            r_exc   <= '0;
`endif
        end else begin
            r_head  <= r_head + w_fire_n[ID_W-1:0];
            r_tail  <= r_tail + w_push_n[ID_W-1:0];
            r_count <= r_count + w_push_n - w_fire_n;
            for (int w = 0; w < WW; w++) begin
                if (wb_valid[w] && r_valid[wb_rob_id[w*ID_W +: ID_W]]) begin
                    r_done[wb_rob_id[w*ID_W +: ID_W]] <= 1'b1;
`ifdef CMT_ROB_EXC_EN
                    r_exc[wb_rob_id[w*ID_W +: ID_W]]  <= wb_exc[w];
`endif
                end
            end
            for (int k = 0; k < CW; k++) begin
                if (cmt_fire[k]) begin
                    r_valid[w_cmt_idx[k]] <= 1'b0;
                    r_done[w_cmt_idx[k]]  <= 1'b0;
                end
            end
            for (int i = 0; i < IW; i++) begin
                if (w_push_ok && rob_push[i]) begin
                    r_valid[w_push_idx[i]] <= 1'b1;
                    r_done[w_push_idx[i]]  <= 1'b0;
`ifdef CMT_ROB_EXC_EN
                    r_exc[w_push_idx[i]]   <= 1'b0;
`endif
                end
            end
        end
    end

    // Payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IW; i++) begin
            if (w_push_ok && rob_push[i]) begin
                r_ent[w_push_idx[i]] <= {rob_lrd[i*LRF_AW +: LRF_AW],
                                         rob_prd[i*PRF_AW +: PRF_AW],
                                         rob_prd_we[i],
                                         rob_pfree[i*PRF_AW +: PRF_AW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && (rob_push_size != '0)) begin
            assert (rob_ready);
        end
    end

endmodule

`default_nettype wire
